// File: rtl/wb_dsp_sequencer.sv
// Wishbone master that fetches an equation block, reduces its operands
// (SUM/MAX/MIN/XOR) and writes the result back to the destination word.
module wb_dsp_sequencer #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int MAX_COUNT   = 16,
    parameter int RETRY_LIMIT = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    input  logic [dw-1:0]   equation_address_reg,
    input  logic [dw-1:0]   control_reg,
    output logic [dw-1:0]   status_reg,
    output logic [dw-1:0]   result_reg
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RETRY_LIMIT + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_HDR, S_FETCH_DST, S_FETCH_OPND,
        S_WRITE_RES, S_DONE, S_ERROR
    } state_t;

    state_t        r_state;
    logic          r_cyc, r_we, r_gap, r_start_d, r_done, r_err;
    logic [aw-1:0] r_adr, r_base, r_dst;
    logic [dw-1:0] r_dat, r_acc, r_result;
    logic [1:0]    r_op;
    logic [7:0]    r_n, r_idx, r_cnt;
    logic [3:0]    r_code;
    logic [TW-1:0] r_tmo;
    logic [RW-1:0] r_rty;

    logic          w_active, w_start, w_stop, w_unused;
    logic [7:0]    w_hdr_op, w_hdr_n;
    logic [aw-1:0] w_adr;
    logic [dw-1:0] w_comb;

    assign w_active = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign w_start  = control_reg[0] && !r_start_d;
    assign w_stop   = control_reg[1];
    assign w_hdr_op = wb_dat_i[7:0];
    assign w_hdr_n  = wb_dat_i[15:8];
    assign w_unused = ^control_reg[dw-1:2];

    always_comb begin
        w_adr = r_base;
        case (r_state)
            S_FETCH_DST:  w_adr = r_base + aw'(4);
            S_FETCH_OPND: w_adr = r_base + aw'(8) + aw'({r_idx, 2'b00});
            S_WRITE_RES:  w_adr = r_dst;
            default:      w_adr = r_base;
        endcase
    end

    always_comb begin
        w_comb = r_acc;
        case (r_op)
            2'd0:    w_comb = r_acc + wb_dat_i;
            2'd1:    w_comb = ($signed(wb_dat_i) > $signed(r_acc)) ? wb_dat_i : r_acc;
            2'd2:    w_comb = ($signed(wb_dat_i) < $signed(r_acc)) ? wb_dat_i : r_acc;
            default: w_comb = r_acc ^ wb_dat_i;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state   <= S_IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_gap     <= 1'b0;
            r_start_d <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_adr     <= '0;
            r_base    <= '0;
            r_dst     <= '0;
            r_dat     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_op      <= '0;
            r_n       <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_code    <= '0;
            r_tmo     <= '0;
            r_rty     <= '0;
        end else begin
            r_start_d <= control_reg[0];
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_FETCH_HDR;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_code  <= '0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_rty   <= '0;
                        r_gap   <= 1'b0;
                        r_base  <= equation_address_reg[aw-1:0];
                    end
                end
                S_FETCH_HDR, S_FETCH_DST, S_FETCH_OPND, S_WRITE_RES: begin
                    if (r_cyc) begin
                        if (wb_err_i) begin
                            r_cyc   <= 1'b0;
                            r_gap   <= 1'b1;
                            r_state <= S_ERROR;
                            r_code  <= 4'd1;
                        end else if (wb_ack_i) begin
                            r_cyc <= 1'b0;
                            r_gap <= 1'b1;
                            r_rty <= '0;
                            if (r_state == S_FETCH_OPND) begin
                                r_acc <= (r_idx == 8'd0) ? wb_dat_i : w_comb;
                                r_cnt <= r_cnt + 8'd1;
                                r_idx <= r_idx + 8'd1;
                            end
                            if (w_stop) begin
                                r_state <= S_ERROR;
                                r_code  <= 4'd6;
                            end else begin
                                case (r_state)
                                    S_FETCH_HDR: begin
                                        if (w_hdr_op > 8'd3) begin
                                            r_state <= S_ERROR;
                                            r_code  <= 4'd2;
                                        end else if (w_hdr_n == 8'd0 ||
                                                     int'(w_hdr_n) > MAX_COUNT) begin
                                            r_state <= S_ERROR;
                                            r_code  <= 4'd3;
                                        end else begin
                                            r_op    <= w_hdr_op[1:0];
                                            r_n     <= w_hdr_n;
                                            r_state <= S_FETCH_DST;
                                        end
                                    end
                                    S_FETCH_DST: begin
                                        r_dst   <= wb_dat_i[aw-1:0];
                                        r_state <= S_FETCH_OPND;
                                    end
                                    S_FETCH_OPND: begin
                                        if (r_idx == r_n - 8'd1)
                                            r_state <= S_WRITE_RES;
                                    end
                                    default: begin
                                        r_result <= r_acc;
                                        r_state  <= S_DONE;
                                    end
                                endcase
                            end
                        end else if (wb_rty_i) begin
                            r_cyc <= 1'b0;
                            r_gap <= 1'b1;
                            if (w_stop) begin
                                r_state <= S_ERROR;
                                r_code  <= 4'd6;
                            end else if (r_rty == RW'(RETRY_LIMIT)) begin
                                r_state <= S_ERROR;
                                r_code  <= 4'd4;
                            end else begin
                                r_rty <= r_rty + RW'(1);
                            end
                        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                            r_cyc   <= 1'b0;
                            r_gap   <= 1'b1;
                            r_state <= S_ERROR;
                            r_code  <= 4'd5;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end else if (r_gap) begin
                        // one idle cycle with cyc low between accesses
                        r_gap <= 1'b0;
                    end else if (w_stop) begin
                        r_state <= S_ERROR;
                        r_code  <= 4'd6;
                    end else begin
                        r_cyc <= 1'b1;
                        r_tmo <= '0;
                        r_adr <= w_adr;
                        r_we  <= (r_state == S_WRITE_RES);
                        r_dat <= (r_state == S_WRITE_RES) ? r_acc : '0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign wb_we_o    = r_we;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_cyc;
    assign wb_sel_o   = {(dw/8){r_cyc}};
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;
    assign status_reg = dw'({r_cnt, r_code, 1'b0, r_err, r_done, w_active});
    assign result_reg = r_result;
endmodule

// File: tb/tb_wb_dsp_sequencer.sv
// Directed bench for wb_dsp_sequencer: a negedge-driven Wishbone slave
// with retry/error/silent knobs and hand-computed expected results.
module tb_wb_dsp_sequencer;
    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic [31:0] equation_address_reg, control_reg, status_reg, result_reg;

    wb_dsp_sequencer dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .equation_address_reg(equation_address_reg),
        .control_reg(control_reg), .status_reg(status_reg),
        .result_reg(result_reg)
    );

    always #5 wb_clk = ~wb_clk;

    logic [31:0] mem [logic [31:0]];
    int n_chk = 0, n_fail = 0;
    int n_acc = 0, n_stb = 0, n_wr = 0, n_rty = 0, n_bad = 0;
    int rty_until = 0;
    bit silent = 1'b0, prev_cyc = 1'b0, prev_stb = 1'b0, prev_we = 1'b0;
    logic [31:0] err_adr = 32'hFFFF_FFFF, wr_adr = '0, wr_dat = '0;
    logic [31:0] prev_adr = '0, prev_dat = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // slave: responds to each strobe at the following rising edge
    always @(negedge wb_clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_stb_o) begin
            n_stb++;
            if (wb_sel_o != 4'hF || wb_cti_o != 3'd0 || wb_bte_o != 2'd0)
                n_bad++;
            if (prev_stb && (wb_adr_o != prev_adr || wb_dat_o != prev_dat ||
                             wb_we_o != prev_we))
                n_bad++;
        end
        if (wb_stb_o != wb_cyc_o) n_bad++;
        if (wb_cyc_o && !prev_cyc) n_acc++;
        prev_cyc = wb_cyc_o;
        prev_stb = wb_stb_o;
        prev_adr = wb_adr_o;
        prev_dat = wb_dat_o;
        prev_we  = wb_we_o;
        if (wb_cyc_o && wb_stb_o && !silent) begin
            if (wb_adr_o == err_adr) begin
                wb_err_i = 1'b1;
            end else if (n_rty < rty_until) begin
                wb_rty_i = 1'b1;
                n_rty++;
            end else begin
                wb_ack_i = 1'b1;
                if (wb_we_o) begin
                    n_wr++;
                    wr_adr = wb_adr_o;
                    wr_dat = wb_dat_o;
                end else begin
                    wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
                end
            end
        end
    end

    task automatic load(input logic [31:0] hdr, input logic [31:0] o0,
                        input logic [31:0] o1, input logic [31:0] o2,
                        input logic [31:0] o3);
        mem[32'h100] = hdr;
        mem[32'h104] = 32'h200;
        mem[32'h108] = o0;
        mem[32'h10C] = o1;
        mem[32'h110] = o2;
        mem[32'h114] = o3;
    endtask

    task automatic pulse_start();
        @(negedge wb_clk) control_reg[0] = 1'b1;
        @(negedge wb_clk) control_reg[0] = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!status_reg[0] && (status_reg[1] || status_reg[2])) begin
                ok = 1'b1;
                break;
            end
            @(negedge wb_clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic run(input string tag);
        pulse_start();
        wait_end(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, w0, s0;
        bit seen;
        wb_rst = 1'b1;
        control_reg = '0;
        equation_address_reg = 32'h100;
        repeat (3) @(negedge wb_clk);
        chk("rst_status", status_reg, 32'h0);
        chk("rst_result", result_reg, 32'h0);
        chk("rst_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        load(32'h0000_0300, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'd0);
        a0 = n_acc;
        run("sum_end");
        chk("sum_wdat", wr_dat, 32'h0000_000B);
        chk("sum_wadr", wr_adr, 32'h200);
        chk("sum_result", result_reg, 32'h0000_000B);
        chk("sum_status", status_reg, 32'h0000_0302);
        chk("sum_accesses", 32'(n_acc - a0), 32'd6);

        load(32'h0000_0401, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFEC, 32'd9);
        run("max_end");
        chk("max_wdat", wr_dat, 32'd9);
        chk("max_status", status_reg, 32'h0000_0402);

        load(32'h0000_0402, 32'hFFFF_FFFD, 32'd9, 32'hFFFF_FFEC, 32'd9);
        run("min_end");
        chk("min_wdat", wr_dat, 32'hFFFF_FFEC);
        chk("min_result", result_reg, 32'hFFFF_FFEC);

        load(32'h0000_0203, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0);
        run("xor_end");
        chk("xor_wdat", wr_dat, 32'h0000_FF00);

        load(32'h0000_0000, 32'd1, 32'd2, 32'd3, 32'd4);
        a0 = n_acc;
        w0 = n_wr;
        run("n0_end");
        chk("n0_status", status_reg, 32'h0000_0034);
        chk("n0_accesses", 32'(n_acc - a0), 32'd1);
        chk("n0_writes", 32'(n_wr - w0), 32'd0);

        load(32'h0000_0307, 32'd1, 32'd2, 32'd3, 32'd4);
        a0 = n_acc;
        run("op7_end");
        chk("op7_status", status_reg, 32'h0000_0024);
        chk("op7_accesses", 32'(n_acc - a0), 32'd1);

        load(32'h0000_1100, 32'd1, 32'd2, 32'd3, 32'd4);
        run("n17_end");
        chk("n17_status", status_reg, 32'h0000_0034);

        load(32'h0000_0300, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'd0);
        a0 = n_acc;
        rty_until = n_rty + 3;
        run("rty3_end");
        chk("rty3_status", status_reg, 32'h0000_0302);
        chk("rty3_wdat", wr_dat, 32'h0000_000B);
        chk("rty3_accesses", 32'(n_acc - a0), 32'd9);

        a0 = n_acc;
        rty_until = n_rty + 4;
        run("rty4_end");
        chk("rty4_status", status_reg, 32'h0000_0044);
        chk("rty4_accesses", 32'(n_acc - a0), 32'd4);
        repeat (20) @(negedge wb_clk);
        chk("rty4_idle", 32'(n_acc - a0), 32'd4);
        chk("rty4_cyc", 32'(wb_cyc_o), 32'd0);

        err_adr = 32'h104;
        a0 = n_acc;
        run("err_end");
        chk("err_status", status_reg, 32'h0000_0014);
        chk("err_accesses", 32'(n_acc - a0), 32'd2);
        err_adr = 32'hFFFF_FFFF;

        a0 = n_acc;
        w0 = n_wr;
        seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (wb_stb_o && wb_adr_o == 32'h10C) begin
                seen = 1'b1;
                break;
            end
            @(negedge wb_clk);
        end
        chk("stop_found", 32'(seen), 32'd1);
        control_reg[1] = 1'b1;
        wait_end("stop_end");
        chk("stop_code", 32'(status_reg[7:0]), 32'h64);
        chk("stop_writes", 32'(n_wr - w0), 32'd0);
        chk("stop_accesses", 32'(n_acc - a0), 32'd4);
        control_reg[1] = 1'b0;
        run("restart_end");
        chk("restart_status", status_reg, 32'h0000_0302);
        chk("restart_result", result_reg, 32'h0000_000B);

        silent = 1'b1;
        s0 = n_stb;
        run("tmo_end");
        chk("tmo_status", 32'(status_reg[7:0]), 32'h54);
        chk("tmo_stb_cycles", 32'(n_stb - s0), 32'd255);

        pulse_start();
        repeat (5) @(negedge wb_clk);
        chk("rstmid_busy", 32'({wb_cyc_o, wb_stb_o}), 32'h3);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        chk("rstmid_ctl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'h0);
        chk("rstmid_adr", wb_adr_o, 32'h0);
        chk("rstmid_status", status_reg, 32'h0);
        chk("rstmid_result", result_reg, 32'h0);
        wb_rst = 1'b0;
        silent = 1'b0;
        a0 = n_acc;
        repeat (5) @(negedge wb_clk);
        chk("rstmid_quiet", 32'(n_acc - a0), 32'd0);

        chk("bus_rules", 32'(n_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_dsp_sequencer.md
WB_DSP_SEQUENCER -- requirements
Module: wb_dsp_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  dw  32  Wishbone data width in bits; multiple of 8.
  aw  32  Wishbone address width in bits.
  MAX_COUNT  16  maximum operand count per equation, 1..255.
  RETRY_LIMIT  3  consecutive wb_rty_i retries tolerated per access.
  TIMEOUT  255  cycles without ack/err/rty before an access is aborted.
REQ-002 The block SHALL have exactly these ports, one per line: name  direction  width  meaning (clock and reset first).
  wb_clk  in  1  the only clock.
  wb_rst  in  1  reset; synchronous, active-high.
  wb_adr_o  out  aw  byte address.
  wb_dat_o  out  dw  write data.
  wb_sel_o  out  dw/8  byte selects.
  wb_we_o  out  1  write enable.
  wb_cyc_o  out  1  cycle.
  wb_stb_o  out  1  strobe.
  wb_cti_o  out  3  cycle type.
  wb_bte_o  out  2  burst type.
  wb_dat_i  in  dw  read data.
  wb_ack_i  in  1  ack.
  wb_err_i  in  1  bus error.
  wb_rty_i  in  1  retry.
  equation_address_reg  in  dw  base address of the equation block.
  control_reg  in  dw  [0] start, [1] stop, others ignored.
  status_reg  out  dw  [0] active, [1] done, [2] error, [7:4] error code, [15:8] operands processed, others 0.
  result_reg  out  dw  last computed result.

Function
REQ-003 Equation block layout at base B = equation_address_reg[aw-1:0], latched at start: word B = header, with [7:0] opcode and [15:8] count N; word B+4 = destination address; operand i (0..N-1) at B+8+4*i.
REQ-004 Opcodes: 0 SUM (modulo 2^dw), 1 MAX (signed), 2 MIN (signed), 3 XOR; any other value gives error code 2.
REQ-005 N=0 or N>MAX_COUNT gives error code 3; no operand reads are issued.
REQ-006 Start is the rising edge of control_reg[0], detected against a registered copy; edges while active are ignored.
REQ-007 States: IDLE, FETCH_HDR, FETCH_DST, FETCH_OPND, WRITE_RES, DONE, ERROR.
REQ-008 IDLE -> FETCH_HDR on start; on entry, done, error and the code are cleared and the count is zeroed.
REQ-009 FETCH_HDR -> FETCH_DST on ack with a valid header; otherwise -> ERROR.
REQ-010 FETCH_DST -> FETCH_OPND on ack; FETCH_OPND loops N times, then -> WRITE_RES.
REQ-011 WRITE_RES -> DONE on ack; DONE -> IDLE after 1 cycle; ERROR -> IDLE after 1 cycle.
REQ-012 Accumulator: loaded with operand 0, then combined with operands 1..N-1 in order; status[15:8] increments on each operand ack.
REQ-013 Every access is a single classic cycle: wb_cti_o=3'b000, wb_bte_o=2'b00, wb_sel_o all ones, and cyc and stb are asserted together from registers.
REQ-014 wb_adr_o, wb_dat_o and wb_we_o SHALL be held stable while stb is high.
REQ-015 cyc and stb SHALL deassert in the cycle after ack, err or rty is sampled high; at least one cycle with cyc low separates accesses.
REQ-016 Write data is the final accumulator; result_reg is updated on the write ack.
REQ-017 wb_err_i -> ERROR with code 1.
REQ-018 wb_rty_i reissues the same access after one idle cycle; the (RETRY_LIMIT+1)th consecutive rty -> ERROR with code 4.
REQ-019 Timeout: a counter runs while stb is high; reaching TIMEOUT -> stb/cyc drop and -> ERROR with code 5.
REQ-020 Simultaneous ack and err SHALL be treated as err.
REQ-021 Stop (control_reg[1] high) SHALL be acted on at the next access boundary: a bus cycle in progress completes, no further access is issued, and the block goes to ERROR with code 6; stop has priority over a completing ack.
REQ-022 status_reg[0] SHALL be high in every state except IDLE, DONE and ERROR.
REQ-023 done is set in DONE; error is set in ERROR; both are sticky until the next start.

Reset
REQ-024 On wb_rst high at a clock edge: state IDLE; all Wishbone outputs 0 (sel, cti and bte 0); status_reg 0; result_reg 0; all counters and the accumulator cleared.
REQ-025 Reset mid-access SHALL drop cyc/stb on the following edge, with no further accesses.

Verification
REQ-026 B=0x100, header 0x0000_0300 (SUM, N=3), dst 0x200, operands 5, 7, 0xFFFF_FFFF -> write 0x0000_000B to 0x200; done=1; status[15:8]=3; 6 accesses total.
REQ-027 Header 0x0000_0401 (MAX, N=4), operands -3, 9, -20, 9 -> write 9; header with opcode 2 and the same operands -> write 0xFFFF_FFEC.
REQ-028 Header N=0 -> error=1, code 3, exactly one bus access; opcode 7 -> code 2.
REQ-029 Slave asserts rty 3 times, then ack -> completes normally; rty 4 times -> code 4, and cyc stays low afterwards.
REQ-030 Stop asserted during the second operand read -> that read completes, no write is issued, code 6; a new start afterwards runs cleanly.
REQ-031 Slave never responds -> stb drops after TIMEOUT cycles, code 5; wb_rst mid-access -> all outputs 0 on the next edge.
